// File: rtl/chip8_pkg.sv
// Shared CHIP-8 memory-path types: arbiter FSM states, default widths, port ids.
package chip8_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK
    } arb_state_t;

    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_DATA_WIDTH = 8;

    localparam int PORT_CPU = 0;
    localparam int PORT_GPU = 1;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester handshakes plus the single-port RAM bus seen by mem_arbiter.
interface mem_arbiter_if
    import chip8_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

    logic [NUM_PORTS-1:0]            req_read;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] req_read_addr;
    logic [NUM_PORTS*DATA_WIDTH-1:0] req_read_data;
    logic [NUM_PORTS-1:0]            req_read_ack;
    logic [NUM_PORTS-1:0]            req_write;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] req_write_addr;
    logic [NUM_PORTS*DATA_WIDTH-1:0] req_write_data;
    logic [NUM_PORTS-1:0]            req_write_ack;
    logic                            mem_en;
    logic                            mem_we;
    logic [ADDR_WIDTH-1:0]           mem_addr;
    logic [DATA_WIDTH-1:0]           mem_wdata;
    logic [DATA_WIDTH-1:0]           mem_rdata;

    modport slave (
        input  req_read, req_read_addr,
        input  req_write, req_write_addr, req_write_data,
        input  mem_rdata,
        output req_read_data, req_read_ack, req_write_ack,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_read, req_read_addr,
        output req_write, req_write_addr, req_write_data,
        output mem_rdata,
        input  req_read_data, req_read_ack, req_write_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational winner select: round-robin after last_grant, or lowest index
// wins when MEM_ARB_FIXED_PRIORITY_EN is defined.
module rr_pick
    import chip8_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int IW        = idx_w(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] pend_i,
    input  logic [IW-1:0]        last_grant_i,
    output logic [NUM_PORTS-1:0] grant_oh_o,
    output logic [IW-1:0]        grant_idx_o,
    output logic                 valid_o
);

`ifdef MEM_ARB_FIXED_PRIORITY_EN
    logic unused_lg;
    assign unused_lg = ^last_grant_i;

    // Descending scan so the lowest pending index is the last one written.
    always_comb begin
        grant_oh_o  = '0;
        grant_idx_o = '0;
        valid_o     = 1'b0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (pend_i[i]) begin
                grant_oh_o    = '0;
                grant_oh_o[i] = 1'b1;
                grant_idx_o   = IW'(i);
                valid_o       = 1'b1;
            end
        end
    end
`else
    int c;

    always_comb begin
        grant_oh_o  = '0;
        grant_idx_o = '0;
        valid_o     = 1'b0;
        c           = 0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            c = (int'(last_grant_i) + i) % NUM_PORTS;
            if (!valid_o && pend_i[c]) begin
                grant_oh_o[c] = 1'b1;
                grant_idx_o   = IW'(c);
                valid_o       = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// NUM_PORTS-way read/write arbiter in front of one single-port sync RAM.
// Define MEM_ARB_FIXED_PRIORITY_EN to swap round-robin for fixed priority.
module mem_arbiter
    import chip8_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input logic          clk,
    input logic          rst_n,
    mem_arbiter_if.slave bus
);

    localparam int IW = idx_w(NUM_PORTS);

    logic [NUM_PORTS-1:0] pend;
    logic [NUM_PORTS-1:0] pick_oh;
    logic [IW-1:0]        pick_idx;
    logic                 pick_vld;
    logic                 pick_wr;

    arb_state_t                      state_q;
    logic [IW-1:0]                   grant_q;
    logic [IW-1:0]                   last_q;
    logic                            op_we_q;
    logic [ADDR_WIDTH-1:0]           addr_q;
    logic [DATA_WIDTH-1:0]           wdata_q;
    logic                            mem_en_q;
    logic                            mem_we_q;
    logic [NUM_PORTS-1:0]            rd_ack_q;
    logic [NUM_PORTS-1:0]            wr_ack_q;
    logic [NUM_PORTS*DATA_WIDTH-1:0] rd_data_q;

    assign pend    = bus.req_read | bus.req_write;
    assign pick_wr = |(pick_oh & bus.req_write);

    rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IW        (IW)
    ) u_pick (
        .pend_i       (pend),
        .last_grant_i (last_q),
        .grant_oh_o   (pick_oh),
        .grant_idx_o  (pick_idx),
        .valid_o      (pick_vld)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            last_q    <= IW'(NUM_PORTS - 1);
            op_we_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mem_en_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            rd_ack_q  <= '0;
            wr_ack_q  <= '0;
            rd_data_q <= '0;
        end else begin
            rd_ack_q <= '0;
            wr_ack_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        grant_q  <= pick_idx;
                        op_we_q  <= pick_wr;
                        mem_we_q <= pick_wr;
                        mem_en_q <= 1'b1;
                        wdata_q  <= bus.req_write_data[pick_idx*DATA_WIDTH +: DATA_WIDTH];
                        // A write beats a same-port read; the read stays pending.
                        if (pick_wr)
                            addr_q <= bus.req_write_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        else
                            addr_q <= bus.req_read_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    state_q  <= WAIT;
                end
                WAIT: begin
                    if (op_we_q) begin
                        wr_ack_q[grant_q] <= 1'b1;
                    end else begin
                        rd_ack_q[grant_q] <= 1'b1;
                        rd_data_q[grant_q*DATA_WIDTH +: DATA_WIDTH] <= bus.mem_rdata;
                    end
                    state_q <= ACK;
                end
                ACK: begin
                    last_q  <= grant_q;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_en        = mem_en_q;
    assign bus.mem_we        = mem_we_q;
    assign bus.mem_addr      = addr_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.req_read_ack  = rd_ack_q;
    assign bus.req_write_ack = wr_ack_q;
    assign bus.req_read_data = rd_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with three ports and a behavioural sync RAM.
module tb_mem_arbiter;
    import chip8_pkg::*;

    localparam int NP = 3;
    localparam int AW = 12;
    localparam int DW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    logic [DW-1:0] ram [0:4095];
    logic [DW-1:0] ram_q   = '0;
    logic          pl_we   = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;
    int            we_cnt  = 0;
    bit            mon_on  = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    assign bus.mem_rdata = ram_q;

    mem_arbiter #(
        .NUM_PORTS  (NP),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always @(posedge clk) begin
        if (pl_we) begin
            ram[pl_addr] <= pl_data;
        end else if (bus.mem_en) begin
            if (bus.mem_we) begin
                ram[bus.mem_addr] <= bus.mem_wdata;
                we_cnt <= we_cnt + 1;
            end else begin
                ram_q <= ram[bus.mem_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [NP*DW-1:0] prev_rd  = '0;
    logic             prev_en  = 1'b0;
    logic             prev_rst = 1'b0;

    always @(negedge clk) begin
        if (mon_on && rst_n && prev_rst) begin
            chk("ack_onehot",
                32'($countones({bus.req_read_ack, bus.req_write_ack}) <= 1), 32'd1);
            chk("mem_en_pulse", 32'(!(bus.mem_en && prev_en)), 32'd1);
            for (int p = 0; p < NP; p++)
                chk("rd_data_stable",
                    32'((bus.req_read_data[p*DW +: DW] === prev_rd[p*DW +: DW])
                        || bus.req_read_ack[p]), 32'd1);
        end
        prev_rd  <= bus.req_read_data;
        prev_en  <= bus.mem_en;
        prev_rst <= rst_n;
    end

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_addr = a;
        pl_data = d;
        pl_we   = 1'b1;
        @(posedge clk);
        #1 pl_we = 1'b0;
    endtask

    task automatic wait_any(input string tag, output int idx);
        idx = -1;
        for (int i = 0; i < 40 && idx < 0; i++) begin
            @(negedge clk);
            for (int p = 0; p < NP; p++)
                if (bus.req_read_ack[p] || bus.req_write_ack[p]) idx = p;
        end
        chk(tag, 32'(idx >= 0), 32'd1);
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        bus.req_read_addr[p*AW +: AW] = a;
        bus.req_read[p] = 1'b1;
    endtask

    task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_write_addr[p*AW +: AW] = a;
        bus.req_write_data[p*DW +: DW] = d;
        bus.req_write[p] = 1'b1;
    endtask

    task automatic rd_data(input int p, output logic [DW-1:0] d);
        d = bus.req_read_data[p*DW +: DW];
    endtask

    int            idx;
    int            w0;
    logic [DW-1:0] d;
`ifdef MEM_ARB_FIXED_PRIORITY_EN
    int exp_order [6] = '{0, 0, 0, 0, 0, 0};
`else
    int exp_order [6] = '{0, 1, 2, 0, 1, 2};
`endif

    initial begin
        bus.req_read       = '0;
        bus.req_write      = '0;
        bus.req_read_addr  = '0;
        bus.req_write_addr = '0;
        bus.req_write_data = '0;

        preload(12'h200, 8'hA2);
        preload(12'h100, 8'h10);
        preload(12'h101, 8'h11);
        preload(12'h102, 8'h12);
        preload(12'h300, 8'h00);

        @(negedge clk);
        chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("rst_acks", 32'({bus.req_read_ack, bus.req_write_ack}), 32'd0);
        chk("rst_rd_data", 32'(bus.req_read_data), 32'd0);
        rst_n  = 1'b1;
        mon_on = 1'b1;

        // Single read with exact cycle latency.
        @(posedge clk);
        #1 set_rd(PORT_CPU, 12'h200);
        @(posedge clk);
        @(negedge clk);
        chk("c1_mem_en", 32'(bus.mem_en), 32'd1);
        chk("c1_mem_we", 32'(bus.mem_we), 32'd0);
        chk("c1_mem_addr", 32'(bus.mem_addr), 32'h200);
        @(negedge clk);
        chk("c2_mem_en", 32'(bus.mem_en), 32'd0);
        chk("c2_rd_ack", 32'(bus.req_read_ack), 32'd0);
        @(negedge clk);
        chk("c3_rd_ack", 32'(bus.req_read_ack), 32'b001);
        rd_data(PORT_CPU, d);
        chk("c3_rd_data", 32'(d), 32'hA2);
        @(posedge clk);
        #1 bus.req_read = '0;
        @(negedge clk);
        chk("c4_rd_ack", 32'(bus.req_read_ack), 32'd0);

        // Write then read on the GPU port.
        @(posedge clk);
        #1 set_wr(PORT_GPU, 12'h300, 8'h55);
        w0 = we_cnt;
        wait_any("wr1_timeout", idx);
        chk("wr1_ack", 32'(bus.req_write_ack), 32'b010);
        @(posedge clk);
        #1 bus.req_write = '0;
        set_rd(PORT_GPU, 12'h300);
        wait_any("rd1_timeout", idx);
        chk("rd1_ack", 32'(bus.req_read_ack), 32'b010);
        rd_data(PORT_GPU, d);
        chk("rd1_data", 32'(d), 32'h55);
        @(posedge clk);
        #1 bus.req_read = '0;
        chk("wr1_strobes", 32'(we_cnt - w0), 32'd1);

        // Reset so port 0 is first, then three continuous requesters.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) set_rd(p, 12'(12'h100 + p));
        for (int k = 0; k < 6; k++) begin
            wait_any("rr_timeout", idx);
            chk("rr_order", 32'(idx), 32'(exp_order[k]));
            if (idx >= 0) begin
                rd_data(idx, d);
                chk("rr_data", 32'(d), 32'(8'h10 + idx));
            end
        end
        @(posedge clk);
        #1 bus.req_read = '0;

        // Same-port write and read: write first.
        @(posedge clk);
        #1;
        set_wr(PORT_CPU, 12'h010, 8'h77);
        set_rd(PORT_CPU, 12'h010);
        wait_any("wr0_timeout", idx);
        chk("same_wr_ack", 32'(bus.req_write_ack), 32'b001);
        chk("same_no_rd_ack", 32'(bus.req_read_ack), 32'd0);
        @(posedge clk);
        #1 bus.req_write = '0;
        wait_any("rd0_timeout", idx);
        chk("same_rd_ack", 32'(bus.req_read_ack), 32'b001);
        rd_data(PORT_CPU, d);
        chk("same_rd_data", 32'(d), 32'h77);
        @(posedge clk);
        #1 bus.req_read = '0;

        // Reset during WAIT abandons the transaction.
        @(posedge clk);
        #1 set_rd(PORT_GPU, 12'h300);
        @(posedge clk);
        @(negedge clk);
        chk("mid_issue_en", 32'(bus.mem_en), 32'd1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_en", 32'(bus.mem_en), 32'd0);
        chk("mid_rst_acks", 32'({bus.req_read_ack, bus.req_write_ack}), 32'd0);
        chk("mid_rst_data", 32'(bus.req_read_data), 32'd0);
        set_rd(PORT_CPU, 12'h200);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_no_ack", 32'({bus.req_read_ack, bus.req_write_ack}), 32'd0);
        end
        rst_n = 1'b1;
        wait_any("post_rst0_timeout", idx);
        chk("post_rst_first", 32'(bus.req_read_ack), 32'b001);
        rd_data(PORT_CPU, d);
        chk("post_rst0_data", 32'(d), 32'hA2);
        @(posedge clk);
        #1 bus.req_read[PORT_CPU] = 1'b0;
        wait_any("post_rst1_timeout", idx);
        chk("post_rst_second", 32'(bus.req_read_ack), 32'b010);
        rd_data(PORT_GPU, d);
        chk("post_rst1_data", 32'(d), 32'h55);
        @(posedge clk);
        #1 bus.req_read = '0;

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised memory access arbiter that sits between the CHIP-8 requesters (CPU, GPU, and future DMA/loader ports) and a single-port synchronous RAM. It generalises the current fixed two-port CPU/GPU memory path to NUM_PORTS requesters. Each port gets a request/acknowledge handshake for both reads and writes. Ports are served with round-robin fairness, and only one RAM access is in flight at a time.

## Interface

Parameters:
- NUM_PORTS, 2, number of requester ports (≥1)
- ADDR_WIDTH, 12, address width in bits
- DATA_WIDTH, 8, data width in bits

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_read  in  NUM_PORTS  per-port read request, level, held until ack
- req_read_addr  in  NUM_PORTS*ADDR_WIDTH  per-port read address, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
- req_read_data  out  NUM_PORTS*DATA_WIDTH  per-port read data, valid when read_ack is high, held until that port's next read ack
- req_read_ack  out  NUM_PORTS  one-cycle read completion pulse
- req_write  in  NUM_PORTS  per-port write request, level, held until ack
- req_write_addr  in  NUM_PORTS*ADDR_WIDTH  per-port write address
- req_write_data  in  NUM_PORTS*DATA_WIDTH  per-port write data
- req_write_ack  out  NUM_PORTS  one-cycle write completion pulse
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable, qualified by mem_en
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_wdata  out  DATA_WIDTH  RAM write data
- mem_rdata  in  DATA_WIDTH  RAM read data, valid exactly one cycle after mem_en with mem_we=0

## Operation

- Pending vector: pend[p] = req_read[p] | req_write[p].
- FSM with four states: IDLE → ISSUE → WAIT → ACK → IDLE.
- IDLE:
  - If pend is non-zero, select the winner: the first port with pend set, searching from (last_grant+1) mod NUM_PORTS upward with wrap-around.
  - Register grant, op (write if req_write[grant], else read), address and write data.
  - Go to ISSUE. If pend is zero, stay in IDLE.
- Same-port read and write both high: the write is served first. The read stays pending and is served on a later grant.
- ISSUE: mem_en=1, mem_we=op, mem_addr/mem_wdata from the registered values. Go to WAIT.
- WAIT: capture mem_rdata into req_read_data[grant] if op is read. Go to ACK.
- ACK:
  - Assert req_read_ack[grant] or req_write_ack[grant] for this cycle only.
  - Set last_grant=grant. Go to IDLE.
- Requester contract: drop the request, or present a new one, on the cycle after it samples ack high. The arbiter samples pend again only in IDLE, so a held request is never double-served.
- Requests that drop before ack are a protocol violation and produce undefined behaviour. The transaction still completes and acks.
- Address and data are sampled only in IDLE. Changes after the grant are ignored.

## Timing

- Reset values (asynchronous, immediate):
  - state=IDLE, last_grant=NUM_PORTS-1 (so port 0 wins first), mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - All acks 0; all req_read_data 0.
- Latency: request seen in IDLE at cycle n, mem_en at n+1, ack at n+3. Best-case throughput is one access per 4 cycles.
- Worst-case wait for a continuously requesting port: (NUM_PORTS-1) other transactions plus its own, i.e. 4*NUM_PORTS cycles.
- NUM_PORTS=1: the grant is always 0 and the round-robin logic degenerates.
- At most one ack bit is high in any cycle across both ack vectors.
- Reset asserted mid-transaction: the transaction is abandoned and no ack is issued. A RAM write already strobed in ISSUE stands.
- mem_en is high only in ISSUE, and for exactly one cycle per transaction.

## Configuration

- MEM_ARB_FIXED_PRIORITY_EN:
  - Defined: the round-robin search is replaced by fixed priority, with the lowest index winning (port 0 = CPU). last_grant is not used for selection.
  - Undefined (default): round-robin as described above.
- All other timing is identical in both modes.

## Structure

- Shared package chip8_pkg holds:
  - arb_state_t enum (IDLE, ISSUE, WAIT, ACK)
  - default ADDR_WIDTH=12 and DATA_WIDTH=8 constants
  - CHIP8 port index constants (PORT_CPU=0, PORT_GPU=1)
- Sub-module rr_pick: combinational, NUM_PORTS-wide. Inputs are pend and last_grant; outputs are a one-hot grant plus its index, and a valid flag. It contains the fixed-priority variant under the macro.
- The RAM itself is external to this block.

## Test plan

- Single read: preload RAM[0x200]=0xA2. Port 0 reads 0x200 → mem_en at cycle 1, read_ack[0] at cycle 3, req_read_data[0]=0xA2.
- Write then read: port 1 writes 0x55 to 0x300, then reads 0x300 → write_ack[1] then read_ack[1], data 0x55. RAM sees mem_we=1 exactly once.
- Contention with 3 ports all requesting continuously → grant order 0,1,2,0,1,2. Without the macro, no port is served twice before the others. With MEM_ARB_FIXED_PRIORITY_EN, port 0 is served every transaction.
- Same-port read and write at once: port 0 has write 0x77 to 0x010 and read 0x010 both high → write acked first, then read returns 0x77.
- Reset mid-operation: rst_n low during WAIT → all outputs reset immediately, no ack. After release, the pending request is re-served from IDLE with port 0 first.
- Protocol checks: one-hot acks, mem_en exactly one cycle per transaction, req_read_data[p] stable between acks.
